// File: rtl/cva5_types.sv
// rtl/cva5_types.sv - shared entry types and byte-mask helper for the load/store forwarding queue
package cva5_types;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  fn3;
    } lq_fwd_entry_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        committed;
    } sq_fwd_entry_t;

    function automatic logic [3:0] load_byte_mask(input logic [2:0] fn3, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (fn3)
            3'b000, 3'b100: mask = 4'b0001 << addr_lo;
            3'b001, 3'b101: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:        mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sq_forward_select.sv
// rtl/sq_forward_select.sv - youngest older matching store search and byte coverage check
module sq_forward_select
    import cva5_types::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  sq_fwd_entry_t               sq_entries_i [SQ_DEPTH],
    input  logic [$clog2(SQ_DEPTH)-1:0] sq_head_i,
    input  lq_fwd_entry_t               load_i,
    input  logic [SQ_DEPTH-1:0]         older_mask_i,
    output logic                        match_o,
    output logic                        covered_o,
    output logic [31:0]                 data_o
);

    localparam int PTR_W = $clog2(SQ_DEPTH);

    logic [PTR_W-1:0] idx;
    logic [3:0]       hit_be;
    logic [5:0]       unused_fields;

    // Walk from the SQ head towards the tail so the last hit is the youngest older store.
    always_comb begin
        match_o       = 1'b0;
        hit_be        = '0;
        data_o        = '0;
        idx           = '0;
        unused_fields = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            idx = sq_head_i + PTR_W'(i);
            unused_fields = unused_fields ^ {sq_entries_i[i].fn3, sq_entries_i[i].committed,
                                             sq_entries_i[i].addr[1:0]};
            if (older_mask_i[idx] && (sq_entries_i[idx].addr[31:2] == load_i.addr[31:2])) begin
                match_o = 1'b1;
                hit_be  = sq_entries_i[idx].be;
                data_o  = sq_entries_i[idx].data;
            end
        end
        covered_o = match_o && ((load_byte_mask(load_i.fn3, load_i.addr[1:0]) & ~hit_be) == 4'b0000);
    end

endmodule

// File: rtl/load_store_forwarding_queue.sv
// rtl/load_store_forwarding_queue.sv - split load/store queues with store-to-load forwarding and one memory port
module load_store_forwarding_queue
    import cva5_types::*;
#(
    parameter int LQ_DEPTH        = 8,
    parameter int SQ_DEPTH        = 4,
    parameter int ID_W            = 3,
    parameter int RETIRE_WIDTH    = 2,
    parameter int DRAIN_MODE      = 1,
    parameter int DRAIN_THRESHOLD = SQ_DEPTH - 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_load,
    input  logic                              in_store,
    input  logic [31:0]                       in_addr,
    input  logic [2:0]                        in_fn3,
    input  logic [3:0]                        in_be,
    input  logic [31:0]                       in_data,
    input  logic [ID_W-1:0]                   in_id,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count,
    input  logic                              flush,
    output logic                              mem_valid,
    input  logic                              mem_ready,
    output logic                              mem_load,
    output logic [31:0]                       mem_addr,
    output logic [2:0]                        mem_fn3,
    output logic [3:0]                        mem_be,
    output logic [31:0]                       mem_data,
    output logic [ID_W-1:0]                   mem_id,
    output logic                              fwd_valid,
    output logic [ID_W-1:0]                   fwd_id,
    output logic [31:0]                       fwd_data,
    output logic                              lq_empty,
    output logic                              sq_empty,
    output logic                              sq_committed_empty
);

    localparam int LQ_PW = $clog2(LQ_DEPTH);
    localparam int SQ_PW = $clog2(SQ_DEPTH);
    localparam int LQ_CW = $clog2(LQ_DEPTH + 1);
    localparam int SQ_CW = $clog2(SQ_DEPTH + 1);

    lq_fwd_entry_t       lq_entry_q [LQ_DEPTH];
    logic [ID_W-1:0]     lq_id_q    [LQ_DEPTH];
    logic [SQ_DEPTH-1:0] lq_mask_q  [LQ_DEPTH];
    logic [SQ_DEPTH-1:0] lq_mask_d  [LQ_DEPTH];
    logic [LQ_PW-1:0]    lq_head_q, lq_head_d, lq_tail_q, lq_tail_d;
    logic [LQ_CW-1:0]    lq_cnt_q, lq_cnt_d;

    sq_fwd_entry_t       sq_entry_q [SQ_DEPTH];
    sq_fwd_entry_t       sq_entry_d [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] sq_valid_q, sq_valid_d, sq_valid_keep;
    logic [SQ_PW-1:0]    sq_head_q, sq_head_d, sq_cptr_q, sq_cptr_d, sq_tail_q, sq_tail_d;
    logic [SQ_CW-1:0]    sq_cnt_q, sq_cnt_d, sq_ccnt_q, sq_ccnt_d;

    logic hold_q, hold_d, hold_store_q, hold_store_d;

    lq_fwd_entry_t lq_head_entry;
    sq_fwd_entry_t sq_head_entry;
    logic          sel_match, sel_covered;
    logic [31:0]   sel_data;
    logic          lq_nonempty, load_issuable, store_issuable, drain_pri;
    logic          hold_load_ok, hold_store_ok, pick_store, pick_load;
    logic          mem_fire, st_pop, ld_pop, push_load, push_store;

    assign lq_head_entry = lq_entry_q[lq_head_q];
    assign sq_head_entry = sq_entry_q[sq_head_q];

    sq_forward_select #(.SQ_DEPTH(SQ_DEPTH)) u_sq_forward_select (
        .sq_entries_i (sq_entry_q),
        .sq_head_i    (sq_head_q),
        .load_i       (lq_head_entry),
        .older_mask_i (lq_mask_q[lq_head_q]),
        .match_o      (sel_match),
        .covered_o    (sel_covered),
        .data_o       (sel_data)
    );

    assign in_ready   = in_load ? (lq_cnt_q < LQ_CW'(LQ_DEPTH)) : (sq_cnt_q < SQ_CW'(SQ_DEPTH));
    assign push_load  = in_valid & in_ready & in_load;
    assign push_store = in_valid & in_ready & in_store;

    assign lq_nonempty    = (lq_cnt_q != '0);
    assign fwd_valid      = lq_nonempty & sel_match & sel_covered;
    assign load_issuable  = lq_nonempty & ~sel_match;
    assign store_issuable = (sq_ccnt_q != '0);
    assign drain_pri      = (DRAIN_MODE == 1) && (sq_cnt_q >= SQ_CW'(DRAIN_THRESHOLD));

    // A stalled request keeps its selection; only a flushed load may give up the port.
    assign hold_load_ok  = hold_q & ~hold_store_q & load_issuable;
    assign hold_store_ok = hold_q & hold_store_q & store_issuable;
    assign pick_store    = hold_store_ok | (~hold_load_ok & store_issuable & (~load_issuable | drain_pri));
    assign pick_load     = ~pick_store & load_issuable;

    assign mem_valid = pick_store | pick_load;
    assign mem_fire  = mem_valid & mem_ready;
    assign st_pop    = mem_fire & pick_store;
    assign ld_pop    = (mem_fire & pick_load) | fwd_valid;

    assign mem_load = pick_load;
    assign mem_addr = pick_store ? sq_head_entry.addr : lq_head_entry.addr;
    assign mem_fn3  = pick_store ? sq_head_entry.fn3  : lq_head_entry.fn3;
    assign mem_be   = pick_store ? sq_head_entry.be
                                 : load_byte_mask(lq_head_entry.fn3, lq_head_entry.addr[1:0]);
    assign mem_data = pick_store ? sq_head_entry.data : '0;
    assign mem_id   = pick_store ? '0 : lq_id_q[lq_head_q];
    assign fwd_id   = lq_id_q[lq_head_q];
    assign fwd_data = sel_data;

    assign lq_empty           = (lq_cnt_q == '0);
    assign sq_empty           = (sq_cnt_q == '0);
    assign sq_committed_empty = (sq_ccnt_q == '0);

    assign hold_d       = mem_valid & ~mem_ready;
    assign hold_store_d = pick_store;

    // Order within the cycle: store pop, then retire, then flush, then the new push.
    always_comb begin
        sq_entry_d = sq_entry_q;
        sq_valid_d = sq_valid_q;
        sq_head_d  = sq_head_q;
        sq_tail_d  = sq_tail_q;
        sq_cnt_d   = sq_cnt_q;
        sq_ccnt_d  = sq_ccnt_q;
        if (st_pop) begin
            sq_valid_d[sq_head_q] = 1'b0;
            sq_head_d = sq_head_q + SQ_PW'(1);
            sq_cnt_d  = sq_cnt_q - SQ_CW'(1);
            sq_ccnt_d = sq_ccnt_q - SQ_CW'(1);
        end
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (i < int'(retire_count)) begin
                sq_entry_d[sq_cptr_q + SQ_PW'(i)].committed = 1'b1;
            end
        end
        sq_cptr_d = sq_cptr_q + SQ_PW'(retire_count);
        sq_ccnt_d = sq_ccnt_d + SQ_CW'(retire_count);
        if (flush) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (!sq_entry_d[i].committed) begin
                    sq_valid_d[i] = 1'b0;
                end
            end
            sq_tail_d = sq_cptr_d;
            sq_cnt_d  = sq_ccnt_d;
        end
        sq_valid_keep = sq_valid_d;
        if (push_store) begin
            sq_entry_d[sq_tail_d] = '{addr: in_addr, be: in_be, data: in_data, fn3: in_fn3, committed: 1'b0};
            sq_valid_d[sq_tail_d] = 1'b1;
            sq_tail_d = sq_tail_d + SQ_PW'(1);
            sq_cnt_d  = sq_cnt_d + SQ_CW'(1);
        end
    end

    always_comb begin
        lq_head_d = lq_head_q;
        lq_tail_d = lq_tail_q;
        lq_cnt_d  = lq_cnt_q;
        for (int j = 0; j < LQ_DEPTH; j++) begin
            lq_mask_d[j] = lq_mask_q[j];
            if (st_pop) begin
                lq_mask_d[j][sq_head_q] = 1'b0;
            end
        end
        if (flush) begin
            lq_head_d = lq_tail_q;
            lq_cnt_d  = '0;
        end else if (ld_pop) begin
            lq_head_d = lq_head_q + LQ_PW'(1);
            lq_cnt_d  = lq_cnt_q - LQ_CW'(1);
        end
        if (push_load) begin
            lq_mask_d[lq_tail_q] = sq_valid_keep;
            lq_tail_d = lq_tail_q + LQ_PW'(1);
            lq_cnt_d  = lq_cnt_d + LQ_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_load) begin
            lq_entry_q[lq_tail_q] <= '{addr: in_addr, fn3: in_fn3};
            lq_id_q[lq_tail_q]    <= in_id;
        end
        lq_mask_q  <= lq_mask_d;
        sq_entry_q <= sq_entry_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lq_head_q    <= '0;
            lq_tail_q    <= '0;
            lq_cnt_q     <= '0;
            sq_valid_q   <= '0;
            sq_head_q    <= '0;
            sq_cptr_q    <= '0;
            sq_tail_q    <= '0;
            sq_cnt_q     <= '0;
            sq_ccnt_q    <= '0;
            hold_q       <= 1'b0;
            hold_store_q <= 1'b0;
        end else begin
            lq_head_q    <= lq_head_d;
            lq_tail_q    <= lq_tail_d;
            lq_cnt_q     <= lq_cnt_d;
            sq_valid_q   <= sq_valid_d;
            sq_head_q    <= sq_head_d;
            sq_cptr_q    <= sq_cptr_d;
            sq_tail_q    <= sq_tail_d;
            sq_cnt_q     <= sq_cnt_d;
            sq_ccnt_q    <= sq_ccnt_d;
            hold_q       <= hold_d;
            hold_store_q <= hold_store_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        int'(retire_count) <= (int'(sq_cnt_q) - int'(sq_ccnt_q)));

endmodule

// File: tb/tb_load_store_forwarding_queue.sv
// tb/tb_load_store_forwarding_queue.sv - directed scoreboard bench for load_store_forwarding_queue
module tb_load_store_forwarding_queue;

    localparam int ID_W = 3;

    typedef struct {
        logic            load;
        logic [31:0]     addr;
        logic [2:0]      fn3;
        logic [3:0]      be;
        logic [31:0]     data;
        logic [ID_W-1:0] id;
    } req_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } fwd_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_load, in_store;
    logic [31:0]     in_addr, in_data;
    logic [2:0]      in_fn3;
    logic [3:0]      in_be;
    logic [ID_W-1:0] in_id;
    logic [1:0]      retire_count;
    logic            flush;
    logic            mem_valid, mem_ready, mem_load;
    logic [31:0]     mem_addr, mem_data;
    logic [2:0]      mem_fn3;
    logic [3:0]      mem_be;
    logic [ID_W-1:0] mem_id;
    logic            fwd_valid;
    logic [ID_W-1:0] fwd_id;
    logic [31:0]     fwd_data;
    logic            lq_empty, sq_empty, sq_committed_empty;

    int checks = 0;
    int errors = 0;
    req_t exp_mem[$];
    fwd_t exp_fwd[$];

    always #5 clk = ~clk;

    load_store_forwarding_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
        .in_store(in_store), .in_addr(in_addr), .in_fn3(in_fn3), .in_be(in_be), .in_data(in_data),
        .in_id(in_id), .retire_count(retire_count), .flush(flush), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_load(mem_load), .mem_addr(mem_addr), .mem_fn3(mem_fn3),
        .mem_be(mem_be), .mem_data(mem_data), .mem_id(mem_id), .fwd_valid(fwd_valid),
        .fwd_id(fwd_id), .fwd_data(fwd_data), .lq_empty(lq_empty), .sq_empty(sq_empty),
        .sq_committed_empty(sq_committed_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_mem();
        req_t e;
        checks++;
        assert (exp_mem.size() != 0) else begin
            errors++;
            $error("FAIL mem_unexpected observed addr=0x%08h load=%0b expected no request", mem_addr, mem_load);
        end
        if (exp_mem.size() != 0) begin
            e = exp_mem.pop_front();
            chk("mem_load", mem_load, e.load);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_fn3", mem_fn3, e.fn3);
            chk("mem_be", mem_be, e.be);
            if (e.load) chk("mem_id", mem_id, e.id);
            else        chk("mem_data", mem_data, e.data);
        end
    endtask

    task automatic check_fwd();
        fwd_t e;
        checks++;
        assert (exp_fwd.size() != 0) else begin
            errors++;
            $error("FAIL fwd_unexpected observed id=%0d data=0x%08h expected no forward", fwd_id, fwd_data);
        end
        if (exp_fwd.size() != 0) begin
            e = exp_fwd.pop_front();
            chk("fwd_id", fwd_id, e.id);
            chk("fwd_data", fwd_data, e.data);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst && mem_valid && mem_ready) check_mem();
        if (!rst && fwd_valid) check_fwd();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [2:0] fn3);
        exp_mem.push_back('{load: 1'b0, addr: a, fn3: fn3, be: be, data: d, id: '0});
    endtask

    task automatic exp_ld(input logic [31:0] a, input logic [2:0] fn3, input logic [3:0] be, input logic [ID_W-1:0] id);
        exp_mem.push_back('{load: 1'b1, addr: a, fn3: fn3, be: be, data: '0, id: id});
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [2:0] fn3);
        in_valid = 1'b1; in_store = 1'b1; in_load = 1'b0;
        in_addr = a; in_data = d; in_be = be; in_fn3 = fn3;
        #1 chk("in_ready_store", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0; in_store = 1'b0;
    endtask

    task automatic push_load(input logic [31:0] a, input logic [2:0] fn3, input logic [ID_W-1:0] id);
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
        in_addr = a; in_fn3 = fn3; in_id = id;
        #1 chk("in_ready_load", in_ready, 1'b1);
        cycle();
        in_valid = 1'b0; in_load = 1'b0;
    endtask

    task automatic retire(input logic [1:0] n);
        retire_count = n;
        cycle();
        retire_count = '0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((exp_mem.size() != 0 || exp_fwd.size() != 0) && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_mem_left", exp_mem.size(), 0);
        chk("drain_fwd_left", exp_fwd.size(), 0);
        repeat (2) cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_addr = '0; in_fn3 = '0;
        in_be = '0; in_data = '0; in_id = '0; retire_count = '0; flush = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        repeat (2) cycle();
        rst = 1'b0;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_lq_empty", lq_empty, 1'b1);
        chk("rst_sq_empty", sq_empty, 1'b1);
        chk("rst_sq_committed_empty", sq_committed_empty, 1'b1);

        // Full-coverage forward of a byte load from an uncommitted word store.
        mem_ready = 1'b1;
        push_store(32'h100, 32'hAABBCCDD, 4'hF, 3'd2);
        exp_fwd.push_back('{id: 3'd1, data: 32'hAABBCCDD});
        push_load(32'h102, 3'd0, 3'd1);
        chk("t1_fwd_valid", fwd_valid, 1'b1);
        chk("t1_fwd_data", fwd_data, 32'hAABBCCDD);
        chk("t1_mem_valid", mem_valid, 1'b0);
        cycle();
        chk("t1_lq_empty", lq_empty, 1'b1);
        exp_st(32'h100, 32'hAABBCCDD, 4'hF, 3'd2);
        retire(2'd1);
        wait_drain(10);

        // Partial coverage stalls the load until the store drains.
        push_store(32'h200, 32'h0000BEEF, 4'h3, 3'd1);
        push_load(32'h200, 3'd2, 3'd2);
        repeat (3) cycle();
        chk("t2_stall_mem_valid", mem_valid, 1'b0);
        chk("t2_stall_fwd_valid", fwd_valid, 1'b0);
        exp_st(32'h200, 32'h0000BEEF, 4'h3, 3'd1);
        exp_ld(32'h200, 3'd2, 4'hF, 3'd2);
        retire(2'd1);
        chk("t2_store_first", mem_load, 1'b0);
        chk("t2_store_valid", mem_valid, 1'b1);
        cycle();
        chk("t2_load_next", mem_load, 1'b1);
        chk("t2_load_valid", mem_valid, 1'b1);
        wait_drain(10);

        // Youngest of two matching stores is forwarded.
        push_store(32'h300, 32'h11111111, 4'hF, 3'd2);
        push_store(32'h300, 32'h22222222, 4'hF, 3'd2);
        exp_fwd.push_back('{id: 3'd3, data: 32'h22222222});
        push_load(32'h300, 3'd2, 3'd3);
        wait_drain(10);
        exp_st(32'h300, 32'h11111111, 4'hF, 3'd2);
        exp_st(32'h300, 32'h22222222, 4'hF, 3'd2);
        retire(2'd2);
        wait_drain(10);

        // Drain priority: store wins at occupancy 3, load wins at 2.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_store(32'h400 + 32'(4 * i), 32'h40000000 + 32'(i), 4'hF, 3'd2);
        retire(2'd2);
        retire(2'd1);
        push_load(32'h500, 3'd2, 3'd4);
        chk("t4_hold_store", mem_load, 1'b0);
        chk("t4_hold_addr", mem_addr, 32'h400);
        exp_st(32'h400, 32'h40000000, 4'hF, 3'd2);
        exp_ld(32'h500, 3'd2, 4'hF, 3'd4);
        exp_st(32'h404, 32'h40000001, 4'hF, 3'd2);
        exp_st(32'h408, 32'h40000002, 4'hF, 3'd2);
        mem_ready = 1'b1;
        wait_drain(20);

        // Full LQ blocks loads but not stores; a stalled request holds its fields.
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_load(32'h1000 + 32'(4 * i), 3'd2, 3'(i));
            exp_ld(32'h1000 + 32'(4 * i), 3'd2, 4'hF, 3'(i));
        end
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
        #1 chk("t5_full_load_ready", in_ready, 1'b0);
        in_valid = 1'b0; in_load = 1'b0;
        push_store(32'h2000, 32'h12345678, 4'hF, 3'd2);
        chk("t5_sq_empty", sq_empty, 1'b0);
        chk("t5_lq_empty", lq_empty, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t5_stable_valid", mem_valid, 1'b1);
            chk("t5_stable_load", mem_load, 1'b1);
            chk("t5_stable_addr", mem_addr, 32'h1000);
            chk("t5_stable_id", mem_id, 3'd0);
            cycle();
        end
        mem_ready = 1'b1;
        wait_drain(30);
        exp_st(32'h2000, 32'h12345678, 4'hF, 3'd2);
        retire(2'd1);
        wait_drain(10);

        // Flush drops loads and uncommitted stores only.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_store(32'h600 + 32'(4 * i), 32'h60000000 + 32'(i), 4'hF, 3'd2);
        retire(2'd2);
        for (int i = 0; i < 3; i++) push_load(32'h700 + 32'(4 * i), 3'd2, 3'(i));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t6_lq_empty", lq_empty, 1'b1);
        chk("t6_sq_empty", sq_empty, 1'b0);
        chk("t6_sq_committed_empty", sq_committed_empty, 1'b0);
        chk("t6_mem_is_store", mem_load, 1'b0);
        exp_st(32'h600, 32'h60000000, 4'hF, 3'd2);
        exp_st(32'h604, 32'h60000001, 4'hF, 3'd2);
        mem_ready = 1'b1;
        wait_drain(20);
        chk("t6_sq_empty_after", sq_empty, 1'b1);
        chk("t6_committed_empty_after", sq_committed_empty, 1'b1);
        push_store(32'h800, 32'h80808080, 4'hF, 3'd2);
        exp_st(32'h800, 32'h80808080, 4'hF, 3'd2);
        retire(2'd1);
        wait_drain(10);

        chk("final_mem_valid", mem_valid, 1'b0);
        chk("final_lq_empty", lq_empty, 1'b1);
        chk("final_sq_empty", sq_empty, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
